simon_core: RTL and testbench
=============================

SIMON_CORE -- requirements
Module: simon_core

Interface
REQ-001 SHALL take parameter N, default 16: word width in bits (16, 24, 32, 48, 64 legal); block is 2N.
REQ-002 SHALL take parameter M, default 4: key words (2, 3, 4 legal).
REQ-003 SHALL take parameter T, default 32: rounds (T > M).
REQ-004 SHALL take parameter Z, default 0: z-sequence index 0..4.
REQ-005 SHALL have ports:
- clk  in  1  sole clock; all state on rising edge.
- R  in  1  synchronous active-high reset.
- key_valid  in  1  key offer.
- key_ready  out  1  key acceptable.
- key  in  M*N  key words, word 0 in LSBs.
- key_loaded  out  1  full schedule present.
- in_valid  in  1  block offer.
- in_ready  out  1  block acceptable.
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled with block.
- in_data  in  2N  plaintext/ciphertext, upper word x.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed.
- out_data  out  2N  result, upper word x.
- busy  out  1  FSM not in IDLE.

Function
REQ-006 SHALL implement FSM IDLE, KEXP, RUN, DONE; transfer = valid && ready on a rising edge.
REQ-007 SHALL assert key_ready only in IDLE; key transfer loads words 0..M-1 into a T x N round-key file, clears key_loaded, sets counter i=M, and enters KEXP.
REQ-008 SHALL in KEXP compute one key per cycle: tmp = k[i-1] ror 3; if M=4, tmp ^= k[i-3]; tmp ^= tmp ror 1; k[i] = ~k[i-M] ^ tmp ^ z_Z[(i-M) mod 62] ^ 3.
REQ-009 SHALL leave KEXP after exactly T-M cycles, setting key_loaded=1 and returning to IDLE.
REQ-010 SHALL assert in_ready only when key_loaded=1 and (state=IDLE, or state=DONE and out_ready=1).
REQ-011 SHALL on block transfer latch enc_dec, load state with in_data (encrypt) or halves-swapped in_data (decrypt), zero round counter r, and enter RUN.
REQ-012 SHALL in RUN apply one round per cycle: x' = y ^ ((x rol 1) & (x rol 8)) ^ (x rol 2) ^ rk, y' = x; rk = k[r] when encrypting, k[T-1-r] when decrypting.
REQ-013 SHALL leave RUN after exactly T cycles into DONE with out_valid=1; out_data = state (encrypt) or halves-swapped state (decrypt); latency from in transfer to out_valid is T+1 edges.
REQ-014 SHALL hold out_data and out_valid stable in DONE until out_ready=1.
REQ-015 SHALL on out transfer go to RUN if a block transfers on the same edge, otherwise to IDLE.
REQ-016 SHALL give key_valid priority over in_valid in IDLE (in_ready low whenever key_valid=1).
REQ-017 SHALL ignore key_valid outside IDLE and keep the current schedule.
REQ-018 SHALL keep key_loaded=1 across any number of blocks until a new key transfer.
REQ-019 SHALL compute counters modulo nothing; widths are $clog2(T+1), with no wrap inside a legal run.

Reset
REQ-020 SHALL on R=1 at a rising edge force state=IDLE, key_loaded=0, out_valid=0, out_data=0, busy=0, counters=0, from any state including mid-KEXP and mid-RUN.
REQ-021 SHALL not require round-key file contents to be reset; they are unreadable while key_loaded=0.
REQ-022 SHALL drive key_ready=1 and in_ready=0 in the first cycle after reset release.

Structure
REQ-023 SHALL take from a shared package the state enum, the five 62-bit z sequences, and a legal-parameter check function.
REQ-024 SHALL instantiate the existing combinational round sub-module simon_round (parameter N) for the REQ-012 datapath.
REQ-025 SHALL fail elaboration on illegal N, M, T or Z.

Verification
REQ-026 SHALL use key 1918 1110 0908 0100 with N=16, M=4, T=32, Z=0: key_loaded rises 28 cycles after key transfer.
REQ-027 SHALL encrypt 6565 6877 under that key -> out_data c69b e9bb, with out_valid 33 edges after transfer.
REQ-028 SHALL decrypt c69b e9bb under that key -> 6565 6877.
REQ-029 SHALL check that out_ready=0 for 10 cycles holds out_data stable; releasing it with in_valid=1 starts the next block on the same edge.
REQ-030 SHALL check that R=1 mid-RUN at round 15 gives out_valid=0 and key_loaded=0, in_ready stays 0 until a new key expands, and in_valid before any key is never accepted.
REQ-031 SHALL check that key_valid and in_valid both high in IDLE accept the key only, and that the following block uses the new schedule.

Source files
------------

// File: rtl/simon_core_pkg.sv
// simon_core_pkg: shared types and constants for the SIMON block cipher core.
//   state_t      - control FSM states
//   Z_SEQ        - the five 62-bit z constant sequences, first bit in bit 61
//   params_legal - parameter legality check used at elaboration
package simon_core_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEXP = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int Z_LEN = 62;

  localparam logic [Z_LEN-1:0] Z_SEQ [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  function automatic logic params_legal(input int n, input int m, input int t, input int z);
    return ((n == 16) || (n == 24) || (n == 32) || (n == 48) || (n == 64)) &&
           (m >= 2) && (m <= 4) && (t > m) && (z >= 0) && (z <= 4);
  endfunction

endpackage

// File: rtl/simon_core_if.sv
// simon_core_if: key, block-in and block-out handshakes of simon_core.
//   key_valid/key_ready/key, key_loaded     - key schedule load and status
//   in_valid/in_ready/enc_dec/in_data       - block offer (upper word x)
//   out_valid/out_ready/out_data            - result (upper word x)
//   busy                                    - core not idle
// master = block user, slave = simon_core.
interface simon_core_if #(
  parameter int N = 16,
  parameter int M = 4
);
  logic             key_valid;
  logic             key_ready;
  logic [M*N-1:0]   key;
  logic             key_loaded;
  logic             in_valid;
  logic             in_ready;
  logic             enc_dec;
  logic [2*N-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   out_data;
  logic             busy;

  modport master (
    output key_valid, key, in_valid, enc_dec, in_data, out_ready,
    input  key_ready, key_loaded, in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  key_valid, key, in_valid, enc_dec, in_data, out_ready,
    output key_ready, key_loaded, in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/simon_round.sv
// simon_round: one combinational SIMON Feistel round.
//   x, y   - current upper/lower words
//   rk     - round key
//   x_next - y ^ f(x) ^ rk,  y_next - x
module simon_round #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] rk,
  output logic [N-1:0] x_next,
  output logic [N-1:0] y_next
);

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  assign x_next = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ rk;
  assign y_next = x;

endmodule

// File: rtl/simon_core.sv
// simon_core: iterative SIMON 2N/MN block cipher, one round per clock.
//   clk  - clock, all state on rising edge
//   R    - synchronous active-high reset
//   bus  - simon_core_if slave: key load, block in, block out, status
// A key transfer expands the full T-word schedule (T-M cycles); blocks are
// then encrypted or decrypted in T cycles each. Decryption runs the same
// round on half-swapped data with the schedule read backwards.
module simon_core
  import simon_core_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4,
  parameter int T = 32,
  parameter int Z = 0
) (
  input logic         clk,
  input logic         R,
  simon_core_if.slave bus
);

  localparam int CW = $clog2(T + 1);
  localparam int AW = $clog2(T);
  localparam logic [Z_LEN-1:0] ZS = Z_SEQ[Z];
  localparam logic [CW-1:0] LAST = CW'(T - 1);

  if (!params_legal(N, M, T, Z)) begin : g_bad_params
    $error("simon_core: illegal N/M/T/Z parameter set");
  end

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  state_t         state;
  logic           key_loaded;
  logic           out_valid;
  logic [2*N-1:0] out_data;
  logic [CW-1:0]  i_cnt;
  logic [CW-1:0]  r_cnt;
  logic [5:0]     z_idx;
  logic           enc;
  logic [N-1:0]   blk_x, blk_y;
  logic [N-1:0]   x_next, y_next;
  logic [N-1:0]   rk;
  logic [N-1:0]   k_tmp, k_new;
  logic [N-1:0]   rk_file [T];
  logic           key_xfer, in_xfer;
  logic [AW-1:0]  idx_m1, idx_m3, idx_mm, idx_wr, idx_rd;
  logic [5:0]     z_pos;

  // handshakes: a pending key always wins over a block in IDLE
  assign key_xfer = bus.key_valid && (state == S_IDLE);
  assign in_xfer  = bus.in_valid && bus.in_ready;

  assign bus.key_ready  = (state == S_IDLE);
  assign bus.in_ready   = key_loaded &&
                          (((state == S_IDLE) && !bus.key_valid) ||
                           ((state == S_DONE) && bus.out_ready));
  assign bus.busy       = (state != S_IDLE);
  assign bus.key_loaded = key_loaded;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;

  // key schedule: word i from words i-1, i-3 (M=4 only) and i-M
  assign idx_m1 = AW'(i_cnt - CW'(1));
  assign idx_m3 = AW'(i_cnt - CW'(3));
  assign idx_mm = AW'(i_cnt - CW'(M));
  assign idx_wr = AW'(i_cnt);
  assign z_pos  = 6'd61 - z_idx;

  always_comb begin
    k_tmp = ror(rk_file[idx_m1], 3);
    if (M == 4) k_tmp = k_tmp ^ rk_file[idx_m3];
    k_tmp = k_tmp ^ ror(k_tmp, 1);
    k_new = ~rk_file[idx_mm] ^ k_tmp ^ N'(3) ^ {{(N-1){1'b0}}, ZS[z_pos]};
  end

  // round datapath
  assign idx_rd = enc ? AW'(r_cnt) : AW'(LAST - r_cnt);
  assign rk     = rk_file[idx_rd];

  simon_round #(.N(N)) u_round (
    .x      (blk_x),
    .y      (blk_y),
    .rk     (rk),
    .x_next (x_next),
    .y_next (y_next)
  );

  always_ff @(posedge clk) begin
    if (key_xfer) begin
      for (int w = 0; w < M; w++) rk_file[AW'(w)] <= bus.key[w*N +: N];
    end else if (state == S_KEXP) begin
      rk_file[idx_wr] <= k_new;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      enc <= bus.enc_dec;
      if (bus.enc_dec) {blk_x, blk_y} <= bus.in_data;
      else             {blk_x, blk_y} <= {bus.in_data[N-1:0], bus.in_data[2*N-1:N]};
    end else if (state == S_RUN) begin
      blk_x <= x_next;
      blk_y <= y_next;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state      <= S_IDLE;
      key_loaded <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      i_cnt      <= '0;
      r_cnt      <= '0;
      z_idx      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_xfer) begin
            state      <= S_KEXP;
            key_loaded <= 1'b0;
            i_cnt      <= CW'(M);
            z_idx      <= '0;
          end else if (in_xfer) begin
            state <= S_RUN;
            r_cnt <= '0;
          end
        end
        S_KEXP: begin
          i_cnt <= i_cnt + CW'(1);
          z_idx <= (z_idx == 6'd61) ? 6'd0 : z_idx + 6'd1;
          if (i_cnt == LAST) begin
            state      <= S_IDLE;
            key_loaded <= 1'b1;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_data  <= enc ? {x_next, y_next} : {y_next, x_next};
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            if (in_xfer) begin
              state <= S_RUN;
              r_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_core.sv
// tb_simon_core: directed, table-driven bench for simon_core (SIMON32/64).
module tb_simon_core;

  localparam int N = 16;
  localparam int M = 4;
  localparam int T = 32;
  localparam int Z = 0;
  localparam logic [63:0] K1 = 64'h1918_1110_0908_0100;
  localparam logic [63:0] K2 = 64'h0123_4567_89ab_cdef;
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

  logic clk = 1'b0;
  logic R = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  simon_core_if #(.N(N), .M(M)) bus ();

  simon_core #(.N(N), .M(M), .T(T), .Z(Z)) dut (
    .clk (clk),
    .R   (R),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        enc;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [15:0] rr(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [15:0] rl(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  // reference SIMON32/64; decryption uses the explicit inverse round
  function automatic logic [31:0] ref_crypt(input logic [63:0] kin, input logic e,
                                            input logic [31:0] din);
    logic [15:0] k [32];
    logic [15:0] tmp, x, y, t;
    for (int j = 0; j < 4; j++) k[j] = kin[16*j +: 16];
    for (int j = 4; j < 32; j++) begin
      tmp  = rr(k[j-1], 3) ^ k[j-3];
      tmp  = tmp ^ rr(tmp, 1);
      k[j] = ~k[j-4] ^ tmp ^ {15'd0, Z0[61-(j-4)]} ^ 16'd3;
    end
    x = din[31:16];
    y = din[15:0];
    if (e) begin
      for (int j = 0; j < 32; j++) begin
        t = x;
        x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ k[j];
        y = t;
      end
    end else begin
      for (int j = 31; j >= 0; j--) begin
        t = y;
        y = x ^ (rl(y, 1) & rl(y, 8)) ^ rl(y, 2) ^ k[j];
        x = t;
      end
    end
    return {x, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic consume(input string nm);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({nm, " out_valid_after_consume"}, bus.out_valid, 0);
    check({nm, " idle_after_consume"}, bus.busy, 0);
  endtask

  task automatic load_key(input string nm, input logic [63:0] k, input logic hold_in);
    int n;
    int leak;
    n = 0;
    leak = 0;
    bus.key       = k;
    bus.key_valid = 1'b1;
    bus.in_valid  = hold_in;
    bus.enc_dec   = 1'b1;
    bus.in_data   = 32'h6565_6877;
    #1;
    check({nm, " key_ready"}, bus.key_ready, 1);
    check({nm, " in_ready_under_key"}, bus.in_ready, 0);
    tick();
    bus.key_valid = 1'b0;
    check({nm, " key_loaded_cleared"}, bus.key_loaded, 0);
    check({nm, " busy_in_kexp"}, bus.busy, 1);
    while (!bus.key_loaded && n < 200) begin
      if (bus.in_ready) leak++;
      tick();
      n++;
    end
    bus.in_valid = 1'b0;
    check({nm, " kexp_cycles"}, n, 28);
    check({nm, " in_ready_during_kexp"}, leak, 0);
  endtask

  task automatic run_block(input string nm, input logic e, input logic [31:0] d,
                           input logic [31:0] exp);
    int n;
    bus.in_valid = 1'b1;
    bus.enc_dec  = e;
    bus.in_data  = d;
    #1;
    check({nm, " in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    wait_out(n);
    check({nm, " latency"}, n, 32);
    check({nm, " data"}, bus.out_data, exp);
    consume(nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [31:0] c;

    bus.key_valid = 1'b0;
    bus.key       = '0;
    bus.in_valid  = 1'b0;
    bus.enc_dec   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{1'b1, 32'h6565_6877, 32'hc69b_e9bb};
    vecs[1] = '{1'b0, 32'hc69b_e9bb, 32'h6565_6877};
    c = ref_crypt(K1, 1'b1, 32'h0000_0000);
    vecs[2] = '{1'b1, 32'h0000_0000, c};
    vecs[3] = '{1'b0, c, 32'h0000_0000};
    vecs[4] = '{1'b1, 32'hffff_ffff, ref_crypt(K1, 1'b1, 32'hffff_ffff)};
    vecs[5] = '{1'b0, 32'h1234_5678, ref_crypt(K1, 1'b0, 32'h1234_5678)};

    // reset and first cycle after release
    R = 1'b1;
    repeat (3) tick();
    R = 1'b0;
    #1;
    check("rst key_ready", bus.key_ready, 1);
    check("rst in_ready", bus.in_ready, 0);
    check("rst key_loaded", bus.key_loaded, 0);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_data", bus.out_data, 0);
    check("rst busy", bus.busy, 0);

    // blocks offered before any key are never taken
    bad = 0;
    bus.in_valid = 1'b1;
    repeat (5) begin
      tick();
      if (bus.in_ready || bus.busy) bad++;
    end
    bus.in_valid = 1'b0;
    check("nokey block_accepted", bad, 0);

    load_key("k1", K1, 1'b0);

    for (int v = 0; v < 6; v++) begin
      run_block($sformatf("vec%0d", v), vecs[v].enc, vecs[v].din, vecs[v].exp);
    end

    // result held under back-pressure, then back-to-back start
    bus.in_valid = 1'b1;
    bus.enc_dec  = 1'b1;
    bus.in_data  = 32'h6565_6877;
    tick();
    bus.in_valid = 1'b0;
    wait_out(n);
    check("hold latency", n, 32);
    bad = 0;
    repeat (10) begin
      tick();
      if (!bus.out_valid || bus.out_data !== 32'hc69b_e9bb) bad++;
    end
    check("hold stable", bad, 0);
    check("hold data", bus.out_data, 32'hc69b_e9bb);
    bus.in_valid  = 1'b1;
    bus.enc_dec   = 1'b0;
    bus.in_data   = 32'hc69b_e9bb;
    bus.out_ready = 1'b1;
    #1;
    check("b2b in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b out_valid_drop", bus.out_valid, 0);
    check("b2b running", bus.busy, 1);
    wait_out(n);
    check("b2b latency", n, 32);
    check("b2b data", bus.out_data, 32'h6565_6877);
    consume("b2b");

    // reset during round 15
    bus.in_valid = 1'b1;
    bus.enc_dec  = 1'b1;
    bus.in_data  = 32'h6565_6877;
    tick();
    bus.in_valid = 1'b0;
    repeat (15) tick();
    check("midrun busy_before_reset", bus.busy, 1);
    R = 1'b1;
    tick();
    R = 1'b0;
    check("midrun out_valid", bus.out_valid, 0);
    check("midrun key_loaded", bus.key_loaded, 0);
    check("midrun busy", bus.busy, 0);
    check("midrun out_data", bus.out_data, 0);
    bad = 0;
    bus.in_valid = 1'b1;
    repeat (5) begin
      #1;
      if (bus.in_ready || bus.busy) bad++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("midrun no_accept", bad, 0);
    load_key("k1_reload", K1, 1'b1);
    run_block("after_reload", 1'b1, 32'h6565_6877, 32'hc69b_e9bb);

    // key and block offered together: key wins, block then uses new schedule
    load_key("k2_prio", K2, 1'b1);
    run_block("k2_enc", 1'b1, 32'h6565_6877, ref_crypt(K2, 1'b1, 32'h6565_6877));
    run_block("k2_dec", 1'b0, ref_crypt(K2, 1'b1, 32'h6565_6877), 32'h6565_6877);
    check("k2 key_loaded_kept", bus.key_loaded, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
